// File: rtl/limit_counter.sv
// limit_counter: up/down counter bounded by a programmable [lo, hi] window.
// A step that would leave the window either wraps to the opposite limit or
// saturates at the limit being crossed. Each crossing raises a one-cycle
// terminal-count pulse (tc) and the sticky overflow flag (ovf).
module limit_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_hi,
    output logic             at_lo,
    output logic             cfg_err
);

    // One extra bit keeps count+step and lo+step from wrapping through 2^WIDTH.
    logic [WIDTH:0] count_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] lo_x;
    logic [WIDTH:0] hi_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] diff_x;
    logic [WIDTH:0] lo_plus_step_x;

    logic             out_of_range;
    logic             step_zero;
    logic             up_cross;
    logic             dn_cross;
    logic             crossing;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;

    assign count_x        = {1'b0, count};
    assign step_x         = {1'b0, step};
    assign lo_x           = {1'b0, lo};
    assign hi_x           = {1'b0, hi};
    assign sum_x          = count_x + step_x;
    assign diff_x         = count_x - step_x;
    assign lo_plus_step_x = lo_x + step_x;

    // Status flags, straight from the current count and the live limits.
    assign cfg_err = (lo > hi);
    assign at_hi   = (count == hi);
    assign at_lo   = (count == lo);

    assign out_of_range = (count < lo) || (count > hi);
    assign step_zero    = (step == '0);
    assign up_cross     = (sum_x > hi_x);
    assign dn_cross     = (count_x < lo_plus_step_x);

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/else chain can leave a latch behind.
        count_next = count;
        tc_next    = 1'b0;
        crossing   = 1'b0;

        if (load) begin
            count_next = init;
        end else if (en) begin
            if (cfg_err) begin
                // Window is inverted: freeze until software fixes the limits.
                count_next = count;
            end else if (out_of_range) begin
                // Re-enter the window at the edge we start counting from.
                count_next = mode ? lo : hi;
            end else if (step_zero) begin
                count_next = count;
            end else if (mode) begin
                if (up_cross) begin
                    crossing   = 1'b1;
                    tc_next    = 1'b1;
                    count_next = SATURATE ? hi : lo;
                end else begin
                    count_next = sum_x[WIDTH-1:0];
                end
            end else begin
                if (dn_cross) begin
                    crossing   = 1'b1;
                    tc_next    = 1'b1;
                    count_next = SATURATE ? lo : hi;
                end else begin
                    count_next = diff_x[WIDTH-1:0];
                end
            end
        end
    end

    // Sticky overflow: load clears, a crossing sets (and beats clr_ovf).
    always_comb begin
        ovf_next = ovf;
        if (load) begin
            ovf_next = 1'b0;
        end else if (crossing) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all three registers are reset here; rst is in the sensitivity
        // list so the clear happens immediately, not on the next clock edge.
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the same pre-edge state.
            count <= count_next;
            tc    <= tc_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_limit_counter.sv
// Testbench for limit_counter: a wrapping instance and a saturating instance
// share one stimulus stream. The driver pushes hand-computed expectations into
// a queue tagged with the cycle they become valid; a monitor pops and compares.
module tb_limit_counter;

    localparam int W = 8;

    typedef struct {
        int         due;
        bit         sel;      // 0 = wrapping instance, 1 = saturating instance
        logic [7:0] count;
        logic       tc;
        logic       ovf;
        logic       at_hi;
        logic       at_lo;
        logic       cfg_err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         mode;
    logic         load;
    logic [W-1:0] init;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] step;
    logic         clr_ovf;

    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;
    logic         at_hi_w, at_hi_s, at_lo_w, at_lo_s, cfg_err_w, cfg_err_s;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    event probe;

    limit_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .init(init), .lo(lo), .hi(hi), .step(step), .clr_ovf(clr_ovf),
        .count(count_w), .tc(tc_w), .ovf(ovf_w),
        .at_hi(at_hi_w), .at_lo(at_lo_w), .cfg_err(cfg_err_w)
    );

    limit_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .init(init), .lo(lo), .hi(hi), .step(step), .clr_ovf(clr_ovf),
        .count(count_s), .tc(tc_s), .ovf(ovf_s),
        .at_hi(at_hi_s), .at_lo(at_lo_s), .cfg_err(cfg_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due.
    initial begin
        forever begin
            @(negedge clk or probe);
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                logic [7:0] c;
                logic t, o, ah, al, ce;
                e = q.pop_front();
                c  = e.sel ? count_s   : count_w;
                t  = e.sel ? tc_s      : tc_w;
                o  = e.sel ? ovf_s     : ovf_w;
                ah = e.sel ? at_hi_s   : at_hi_w;
                al = e.sel ? at_lo_s   : at_lo_w;
                ce = e.sel ? cfg_err_s : cfg_err_w;
                n_checks++;
                if (e.due != cyc) begin
                    n_fail++;
                    $display("FAIL stale_expectation sel=%0d due=%0d now=%0d", e.sel, e.due, cyc);
                end else if (c !== e.count || t !== e.tc || o !== e.ovf ||
                             ah !== e.at_hi || al !== e.at_lo || ce !== e.cfg_err) begin
                    n_fail++;
                    $display("FAIL cycle%0d_%s got count=%02h tc=%b ovf=%b at_hi=%b at_lo=%b cfg_err=%b exp count=%02h tc=%b ovf=%b at_hi=%b at_lo=%b cfg_err=%b",
                             cyc, e.sel ? "sat" : "wrap", c, t, o, ah, al, ce,
                             e.count, e.tc, e.ovf, e.at_hi, e.at_lo, e.cfg_err);
                end
            end
        end
    end

    task automatic drive(input logic l, input logic e, input logic m,
                         input logic [7:0] ini, input logic [7:0] lo_v,
                         input logic [7:0] hi_v, input logic [7:0] st,
                         input logic clr);
        @(negedge clk);
        #1;
        load = l; en = e; mode = m; init = ini;
        lo = lo_v; hi = hi_v; step = st; clr_ovf = clr;
    endtask

    task automatic expect_out(input bit sel, input int due, input logic [7:0] c,
                              input logic t, input logic o, input logic ah,
                              input logic al, input logic ce);
        exp_t e;
        e.due = due; e.sel = sel; e.count = c; e.tc = t; e.ovf = o;
        e.at_hi = ah; e.at_lo = al; e.cfg_err = ce;
        q.push_back(e);
    endtask

    // Expect the same outcome from both instances after the next edge.
    task automatic expect_both(input logic [7:0] c, input logic t, input logic o,
                               input logic ah, input logic al, input logic ce);
        expect_out(1'b0, cyc + 1, c, t, o, ah, al, ce);
        expect_out(1'b1, cyc + 1, c, t, o, ah, al, ce);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b1; load = 1'b0; init = '0;
        lo = 8'd10; hi = 8'd20; step = 8'd3; clr_ovf = 1'b0;

        // Reset state, then release with enable low: count holds at 0.
        drive(0, 0, 1, 8'h00, 8'd10, 8'd20, 8'd3, 0);
        rst = 1'b1;
        expect_both(8'd0, 0, 0, 0, 0, 0);

        // Wrap up: lo=10 hi=20 step=3 from 18.
        drive(1, 1, 1, 8'd18, 8'd10, 8'd20, 8'd3, 0);
        expect_both(8'd18, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 8'd0, 8'd10, 8'd20, 8'd3, 0);
        expect_out(0, cyc + 1, 8'd10, 1, 1, 0, 1, 0);
        expect_out(1, cyc + 1, 8'd20, 1, 1, 1, 0, 0);
        drive(0, 1, 1, 8'd0, 8'd10, 8'd20, 8'd3, 0);
        expect_out(0, cyc + 1, 8'd13, 0, 1, 0, 0, 0);
        expect_out(1, cyc + 1, 8'd20, 1, 1, 1, 0, 0);
        // Hold with clr_ovf and no crossing: ovf clears, tc drops.
        drive(0, 0, 1, 8'd0, 8'd10, 8'd20, 8'd3, 1);
        expect_out(0, cyc + 1, 8'd13, 0, 0, 0, 0, 0);
        expect_out(1, cyc + 1, 8'd20, 0, 0, 1, 0, 0);

        // Saturate down: lo=5 hi=50 step=2 from 6.
        drive(1, 1, 0, 8'd6, 8'd5, 8'd50, 8'd2, 0);
        expect_both(8'd6, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 8'd0, 8'd5, 8'd50, 8'd2, 0);
        expect_out(0, cyc + 1, 8'd50, 1, 1, 1, 0, 0);
        expect_out(1, cyc + 1, 8'd5, 1, 1, 0, 1, 0);
        // clr_ovf races a crossing on the saturating instance: set wins.
        drive(0, 1, 0, 8'd0, 8'd5, 8'd50, 8'd2, 1);
        expect_out(0, cyc + 1, 8'd48, 0, 0, 0, 0, 0);
        expect_out(1, cyc + 1, 8'd5, 1, 1, 0, 1, 0);

        // Full-range wrap: lo=0 hi=255 step=1.
        drive(1, 1, 1, 8'd255, 8'd0, 8'd255, 8'd1, 0);
        expect_both(8'd255, 0, 0, 1, 0, 0);
        drive(0, 1, 1, 8'd0, 8'd0, 8'd255, 8'd1, 0);
        expect_out(0, cyc + 1, 8'd0, 1, 1, 0, 1, 0);
        expect_out(1, cyc + 1, 8'd255, 1, 1, 1, 0, 0);
        drive(0, 1, 0, 8'd0, 8'd0, 8'd255, 8'd1, 0);
        expect_out(0, cyc + 1, 8'd255, 1, 1, 1, 0, 0);
        expect_out(1, cyc + 1, 8'd254, 0, 1, 0, 0, 0);

        // Load beats enable and clears ovf; then out-of-range recovery to lo.
        drive(1, 1, 1, 8'h80, 8'd0, 8'd255, 8'd1, 0);
        expect_both(8'h80, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 8'd0, 8'h90, 8'hFF, 8'd1, 0);
        expect_both(8'h90, 0, 0, 0, 1, 0);

        // Inverted window: count holds, cfg_err up; load still lands.
        drive(0, 1, 1, 8'd0, 8'd30, 8'd20, 8'd1, 0);
        expect_both(8'h90, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 8'h25, 8'd30, 8'd20, 8'd1, 0);
        expect_both(8'h25, 0, 0, 0, 0, 1);

        // Zero step while enabled: hold.
        drive(0, 1, 1, 8'd0, 8'd0, 8'd255, 8'd0, 0);
        expect_both(8'h25, 0, 0, 0, 0, 0);

        // Reach 0x37 while counting, then drop rst between edges.
        drive(1, 1, 1, 8'h36, 8'd0, 8'd255, 8'd1, 0);
        expect_both(8'h36, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 8'd0, 8'd0, 8'd255, 8'd1, 0);
        expect_both(8'h37, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        expect_out(0, cyc, 8'd0, 0, 0, 0, 1, 0);
        expect_out(1, cyc, 8'd0, 0, 0, 0, 1, 0);
        -> probe;

        // First edge after release counts up from 0.
        drive(0, 1, 1, 8'd0, 8'd0, 8'd255, 8'd1, 0);
        rst = 1'b1;
        expect_both(8'd1, 0, 0, 0, 0, 0);

        // Drain: give the monitor a few cycles, then confirm nothing is left.
        drive(0, 0, 1, 8'd0, 8'd0, 8'd255, 8'd1, 0);
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending, exp 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/limit_counter.md
LIMIT_COUNTER -- requirements
Module: limit_counter

Interface
REQ-001 The block SHALL provide the parameter WIDTH, default 8, which sets the counter and all data port width in bits (WIDTH >= 2).
REQ-002 The block SHALL provide the parameter SATURATE, default 0: 0 = wrap at the limits, 1 = saturate at the limits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 mode  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous load of init.
REQ-008 init  input  WIDTH  load value.
REQ-009 lo  input  WIDTH  lower limit, inclusive, unsigned.
REQ-010 hi  input  WIDTH  upper limit, inclusive, unsigned.
REQ-011 step  input  WIDTH  increment/decrement magnitude, unsigned.
REQ-012 clr_ovf  input  1  synchronous clear of the ovf flag.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 tc  output  1  registered terminal-count pulse.
REQ-015 ovf  output  1  sticky flag, set when a limit crossing occurs.
REQ-016 at_hi, at_lo  output  1 each  combinational: count == hi, count == lo.
REQ-017 cfg_err  output  1  combinational: lo > hi.

Function
REQ-018 Priority per cycle SHALL be: load > en > hold.
REQ-019 load: count <= init regardless of range; tc <= 0; ovf <= 0.
REQ-020 en low, load low: count holds; tc <= 0.
REQ-021 Arithmetic SHALL be WIDTH+1 bits unsigned, so that count+step and count-step never alias through 2^WIDTH.
REQ-022 Up, in range: if count+step <= hi then count <= count+step and tc <= 0; else a crossing occurs.
REQ-023 Down, in range: if count >= lo+step (WIDTH+1-bit compare) then count <= count-step and tc <= 0; else a crossing occurs.
REQ-024 Crossing with SATURATE=0: count <= lo when up, hi when down.
REQ-025 Crossing with SATURATE=1: count <= hi when up, lo when down.
REQ-026 Every crossing SHALL set tc <= 1 for that cycle only and set ovf <= 1.
REQ-027 In saturate mode, tc SHALL re-assert on every enabled cycle that attempts to pass the held limit.
REQ-028 Out of range (count < lo or count > hi) while enabled: count <= lo when up, hi when down; tc <= 0; ovf unchanged.
REQ-029 step == 0 while enabled: count holds; tc <= 0.
REQ-030 cfg_err high: count holds; tc <= 0; load still takes effect.
REQ-031 clr_ovf: ovf <= 0, except when a crossing occurs in the same cycle, where set SHALL win.
REQ-032 Limits and step are sampled each cycle; a change takes effect on the next enabled edge, with no internal pipeline.

Reset
REQ-033 rst low SHALL immediately force count = 0, tc = 0, ovf = 0, independent of clk, including mid-count.
REQ-034 The first edge after rst deasserts SHALL behave per REQ-018 to REQ-032, with count = 0 as current state.

Verification
REQ-035 Reset mid-run: count = 0x37, en = 1, drop rst between edges -> count = 0, tc = 0, ovf = 0 before the next edge.
REQ-036 Wrap up: WIDTH=8, lo=10, hi=20, step=3, count=18, en=1, mode=1 -> next count = 10, tc = 1 for one cycle, ovf = 1; following cycle count = 13, tc = 0.
REQ-037 Saturate down: SATURATE=1, lo=5, hi=50, step=2, count=6, mode=0 -> count = 5, tc = 1; next cycle count = 5, tc = 1 again.
REQ-038 Full-range wrap: lo=0, hi=255, step=1, count=255, mode=1 -> count = 0, tc = 1; and count=0, mode=0 -> count = 255, tc = 1.
REQ-039 Load priority: load = en = 1, init = 0x80, ovf = 1 -> count = 0x80, tc = 0, ovf = 0; then with lo=0x90 and mode=1 -> count = 0x90 (out-of-range recovery), tc = 0.
REQ-040 Misconfiguration and flag race: lo=30, hi=20 -> cfg_err = 1 and count holds; clr_ovf asserted on a crossing cycle -> ovf remains 1.
